// File: rtl/c2c_rx_aligner.sv
// rtl/c2c_rx_aligner.sv - C2C receive comma aligner with lock FSM (optional stats: C2C_RX_ALIGNER_STATS_EN)
module c2c_rx_aligner #(
   parameter int LOCK_COUNT     = 16,
   parameter int LOSS_ERR_COUNT = 4,
   parameter int GOOD_WORDS     = 64
) (
   input  logic        c2c_phy_clk,
   input  logic        c2c_phy_rst_n,
   input  logic [31:0] gt_rx_data,
   input  logic [3:0]  gt_rx_k,
   input  logic [3:0]  gt_rx_disperr,
   input  logic [3:0]  gt_rx_notintable,
   output logic [31:0] mgt_rx_data,
   output logic [3:0]  mgt_rx_k,
   output logic        rx_aligned
`ifdef C2C_RX_ALIGNER_STATS_EN
   ,
   output logic [15:0] realign_cnt,
   output logic [15:0] err_word_cnt
`endif
);

   localparam int LOCK_W = $clog2(LOCK_COUNT + 1);
   localparam int ERR_W  = $clog2(LOSS_ERR_COUNT + 1);
   localparam int GOOD_W = $clog2(GOOD_WORDS + 1);

   localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_COUNT);
   localparam logic [ERR_W-1:0]  ERR_MAX  = ERR_W'(LOSS_ERR_COUNT);
   localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(GOOD_WORDS);

   typedef enum logic [1:0] {
      ST_HUNT     = 2'd0,
      ST_VERIFY   = 2'd1,
      ST_ALIGNED  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [1:0]         r_q, r_d;
   logic [LOCK_W-1:0]  lock_cnt_q, lock_cnt_d, lock_inc;
   logic [ERR_W-1:0]   err_score_q, err_score_d, err_inc;
   logic [GOOD_W-1:0]  good_cnt_q, good_cnt_d, good_inc;
   logic               rx_aligned_q, rx_aligned_d;

   logic [31:0]        prev_data_q, prev_data_d;
   logic [3:0]         prev_k_q, prev_k_d;
   logic [31:0]        mgt_rx_data_q, mgt_rx_data_d;
   logic [3:0]         mgt_rx_k_q, mgt_rx_k_d;

   logic [3:0]         comma_vec;
   logic               comma_found;
   logic [1:0]         comma_lane;
   logic               word_err;
   logic               bad_comma;
   logic [63:0]        w_data;
   logic [7:0]         w_k;

   // Classify the incoming word: comma lanes (lowest wins) and error flags
   always_comb begin
      comma_vec = '0;
      for (int i = 0; i < 4; i++) begin
         comma_vec[i] = gt_rx_k[i] && (gt_rx_data[8*i +: 8] == 8'hBC);
      end
      comma_found = |comma_vec;
      comma_lane  = 2'd0;
      if (comma_vec[0]) begin
         comma_lane = 2'd0;
      end else if (comma_vec[1]) begin
         comma_lane = 2'd1;
      end else if (comma_vec[2]) begin
         comma_lane = 2'd2;
      end else if (comma_vec[3]) begin
         comma_lane = 2'd3;
      end
      word_err  = (|gt_rx_disperr) || (|gt_rx_notintable);
      bad_comma = comma_found && (comma_lane != r_q);
   end

   // Saturating increments shared by the FSM
   always_comb begin
      lock_inc = (lock_cnt_q == LOCK_MAX) ? lock_cnt_q : lock_cnt_q + LOCK_W'(1);
      err_inc  = (err_score_q == ERR_MAX) ? err_score_q : err_score_q + ERR_W'(1);
      good_inc = (good_cnt_q == GOOD_MAX) ? good_cnt_q : good_cnt_q + GOOD_W'(1);
   end

   // Lock FSM next-state: hunt for a comma, verify its lane, then track errors while aligned
   always_comb begin
      state_d     = state_q;
      r_d         = r_q;
      lock_cnt_d  = lock_cnt_q;
      err_score_d = err_score_q;
      good_cnt_d  = good_cnt_q;
      case (state_q)
         ST_HUNT: begin
            if (comma_found && !word_err) begin
               r_d        = comma_lane;
               lock_cnt_d = LOCK_W'(1);
               if (LOCK_COUNT <= 1) begin
                  state_d     = ST_ALIGNED;
                  err_score_d = '0;
                  good_cnt_d  = '0;
               end else begin
                  state_d = ST_VERIFY;
               end
            end
         end
         ST_VERIFY: begin
            if (word_err || bad_comma) begin
               state_d    = ST_HUNT;
               lock_cnt_d = '0;
               // A clean comma on a new lane becomes the next candidate rotation
               if (!word_err) begin
                  r_d = comma_lane;
               end
            end else if (comma_found) begin
               lock_cnt_d = lock_inc;
               if (lock_inc == LOCK_MAX) begin
                  state_d     = ST_ALIGNED;
                  err_score_d = '0;
                  good_cnt_d  = '0;
               end
            end
         end
         ST_ALIGNED: begin
            if (word_err || bad_comma) begin
               good_cnt_d  = '0;
               err_score_d = err_inc;
               if (err_inc == ERR_MAX) begin
                  state_d     = ST_HUNT;
                  lock_cnt_d  = '0;
                  err_score_d = '0;
               end
            end else begin
               good_cnt_d = good_inc;
               if (good_inc == GOOD_MAX) begin
                  good_cnt_d = '0;
                  if (err_score_q != '0) begin
                     err_score_d = err_score_q - ERR_W'(1);
                  end
               end
            end
         end
         default: begin
            state_d    = ST_HUNT;
            lock_cnt_d = '0;
         end
      endcase
      rx_aligned_d = (state_d == ST_ALIGNED);
   end

   // Lock FSM and counter registers
   always_ff @(posedge c2c_phy_clk or negedge c2c_phy_rst_n) begin
      if (!c2c_phy_rst_n) begin
         state_q      <= ST_HUNT;
         r_q          <= '0;
         lock_cnt_q   <= '0;
         err_score_q  <= '0;
         good_cnt_q   <= '0;
         rx_aligned_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         r_q          <= r_d;
         lock_cnt_q   <= lock_cnt_d;
         err_score_q  <= err_score_d;
         good_cnt_q   <= good_cnt_d;
         rx_aligned_q <= rx_aligned_d;
      end
   end

   // Byte rotation: pick four bytes starting at lane r from {current, previous}
   always_comb begin
      prev_data_d = gt_rx_data;
      prev_k_d    = gt_rx_k;
      w_data      = {gt_rx_data, prev_data_q};
      w_k         = {gt_rx_k, prev_k_q};
      case (r_q)
         2'd0: begin
            mgt_rx_data_d = w_data[31:0];
            mgt_rx_k_d    = w_k[3:0];
         end
         2'd1: begin
            mgt_rx_data_d = w_data[39:8];
            mgt_rx_k_d    = w_k[4:1];
         end
         2'd2: begin
            mgt_rx_data_d = w_data[47:16];
            mgt_rx_k_d    = w_k[5:2];
         end
         default: begin
            mgt_rx_data_d = w_data[55:24];
            mgt_rx_k_d    = w_k[6:3];
         end
      endcase
   end

   // Data path registers run in every state
   always_ff @(posedge c2c_phy_clk or negedge c2c_phy_rst_n) begin
      if (!c2c_phy_rst_n) begin
         prev_data_q   <= '0;
         prev_k_q      <= '0;
         mgt_rx_data_q <= '0;
         mgt_rx_k_q    <= '0;
      end else begin
         prev_data_q   <= prev_data_d;
         prev_k_q      <= prev_k_d;
         mgt_rx_data_q <= mgt_rx_data_d;
         mgt_rx_k_q    <= mgt_rx_k_d;
      end
   end

   assign mgt_rx_data = mgt_rx_data_q;
   assign mgt_rx_k    = mgt_rx_k_q;
   assign rx_aligned  = rx_aligned_q;

`ifdef C2C_RX_ALIGNER_STATS_EN
   logic [15:0] realign_cnt_q, realign_cnt_d;
   logic [15:0] err_word_cnt_q, err_word_cnt_d;

   // Saturating counts of lock losses and errored words
   always_comb begin
      realign_cnt_d  = realign_cnt_q;
      err_word_cnt_d = err_word_cnt_q;
      if ((state_q == ST_ALIGNED) && (state_d == ST_HUNT) && (realign_cnt_q != 16'hFFFF)) begin
         realign_cnt_d = realign_cnt_q + 16'd1;
      end
      if (word_err && (err_word_cnt_q != 16'hFFFF)) begin
         err_word_cnt_d = err_word_cnt_q + 16'd1;
      end
   end

   // Statistics registers
   always_ff @(posedge c2c_phy_clk or negedge c2c_phy_rst_n) begin
      if (!c2c_phy_rst_n) begin
         realign_cnt_q  <= '0;
         err_word_cnt_q <= '0;
      end else begin
         realign_cnt_q  <= realign_cnt_d;
         err_word_cnt_q <= err_word_cnt_d;
      end
   end

   assign realign_cnt  = realign_cnt_q;
   assign err_word_cnt = err_word_cnt_q;
`endif

endmodule

// File: tb/tb_c2c_rx_aligner.sv
// tb/tb_c2c_rx_aligner.sv - directed table-driven bench for c2c_rx_aligner
module tb_c2c_rx_aligner;

   logic        clk;
   logic        rst_n;
   logic [31:0] gt_rx_data;
   logic [3:0]  gt_rx_k;
   logic [3:0]  gt_rx_disperr;
   logic [3:0]  gt_rx_notintable;
   logic [31:0] mgt_rx_data;
   logic [3:0]  mgt_rx_k;
   logic        rx_aligned;
`ifdef C2C_RX_ALIGNER_STATS_EN
   logic [15:0] realign_cnt;
   logic [15:0] err_word_cnt;
`endif

   int checks = 0;
   int errors = 0;

   c2c_rx_aligner dut (
      .c2c_phy_clk      (clk),
      .c2c_phy_rst_n    (rst_n),
      .gt_rx_data       (gt_rx_data),
      .gt_rx_k          (gt_rx_k),
      .gt_rx_disperr    (gt_rx_disperr),
      .gt_rx_notintable (gt_rx_notintable),
      .mgt_rx_data      (mgt_rx_data),
      .mgt_rx_k         (mgt_rx_k),
      .rx_aligned       (rx_aligned)
`ifdef C2C_RX_ALIGNER_STATS_EN
      ,
      .realign_cnt      (realign_cnt),
      .err_word_cnt     (err_word_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] d;
      logic [3:0]  k;
      logic [3:0]  de;
      logic [3:0]  nit;
      logic [31:0] exp_d;
      logic [3:0]  exp_k;
      logic        exp_al;
   } vec_t;

   vec_t tbl[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one word just after a rising edge, then sample 1 ns after the next edge
   task automatic step(input logic [31:0] d, input logic [3:0] k, input logic [3:0] de, input logic [3:0] nit);
      gt_rx_data       = d;
      gt_rx_k          = k;
      gt_rx_disperr    = de;
      gt_rx_notintable = nit;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      gt_rx_data       = '0;
      gt_rx_k          = '0;
      gt_rx_disperr    = '0;
      gt_rx_notintable = '0;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      // Rotation table, applied right after reset (r=0, HUNT)
      tbl[0]  = '{32'h11223344, 4'h0, 4'h0, 4'h0, 32'h00000000, 4'h0, 1'b0};
      tbl[1]  = '{32'hAABBCCDD, 4'h0, 4'h0, 4'h0, 32'h11223344, 4'h0, 1'b0};
      tbl[2]  = '{32'h0000BC00, 4'h2, 4'h0, 4'h0, 32'hAABBCCDD, 4'h0, 1'b0};
      tbl[3]  = '{32'h55667788, 4'h0, 4'h0, 4'h0, 32'h880000BC, 4'h1, 1'b0};
      tbl[4]  = '{32'h12345678, 4'h0, 4'h0, 4'h0, 32'h78556677, 4'h0, 1'b0};
      tbl[5]  = '{32'hBC000000, 4'h8, 4'h0, 4'h0, 32'h00123456, 4'h0, 1'b0};
      tbl[6]  = '{32'h000000BC, 4'h1, 4'h0, 4'h0, 32'h0000BCBC, 4'h3, 1'b0};
      tbl[7]  = '{32'h9ABCDEF0, 4'h0, 4'h1, 4'h0, 32'h000000BC, 4'h1, 1'b0};
      tbl[8]  = '{32'hBC0000BC, 4'h9, 4'h0, 4'h0, 32'h9ABCDEF0, 4'h0, 1'b0};
      tbl[9]  = '{32'h01020304, 4'h0, 4'h0, 4'h0, 32'hBC0000BC, 4'h9, 1'b0};
      tbl[10] = '{32'hBCBC0000, 4'hC, 4'h0, 4'h4, 32'h01020304, 4'h0, 1'b0};
      tbl[11] = '{32'h00000000, 4'h0, 4'h0, 4'h0, 32'hBCBC0000, 4'hC, 1'b0};

      // Reset values
      gt_rx_data = '0; gt_rx_k = '0; gt_rx_disperr = '0; gt_rx_notintable = '0;
      rst_n = 1'b0;
      #12;
      chk("rst_data", mgt_rx_data, 32'h0);
      chk("rst_k", {28'h0, mgt_rx_k}, 32'h0);
      chk("rst_aligned", {31'h0, rx_aligned}, 32'h0);
`ifdef C2C_RX_ALIGNER_STATS_EN
      chk("rst_realign", {16'h0, realign_cnt}, 32'h0);
      chk("rst_errword", {16'h0, err_word_cnt}, 32'h0);
`endif
      do_reset();

      // Table: rotation, lowest-lane comma, lane change and errors in VERIFY
      for (int i = 0; i < 12; i++) begin
         step(tbl[i].d, tbl[i].k, tbl[i].de, tbl[i].nit);
         chk($sformatf("tbl%0d_data", i), mgt_rx_data, tbl[i].exp_d);
         chk($sformatf("tbl%0d_k", i), {28'h0, mgt_rx_k}, {28'h0, tbl[i].exp_k});
         chk($sformatf("tbl%0d_aligned", i), {31'h0, rx_aligned}, {31'h0, tbl[i].exp_al});
      end

      // Lock on lane 2 with interleaved data words
      do_reset();
      for (int i = 0; i < 16; i++) begin
         step(32'h00BC0000, 4'b0100, 4'h0, 4'h0);
         chk($sformatf("lock2_al_c%0d", i), {31'h0, rx_aligned}, {31'h0, (i == 15)});
         step(32'h00000000, 4'h0, 4'h0, 4'h0);
         chk($sformatf("lock2_data%0d", i), mgt_rx_data, 32'h000000BC);
         chk($sformatf("lock2_k%0d", i), {28'h0, mgt_rx_k}, 32'h1);
         chk($sformatf("lock2_al_d%0d", i), {31'h0, rx_aligned}, {31'h0, (i == 15)});
      end

      // Four errors separated by ten clean words drop lock
      for (int e = 0; e < 4; e++) begin
         step((e == 3) ? 32'hCAFE0000 : 32'h0, 4'h0, 4'h1, 4'h0);
         chk($sformatf("loss_err%0d", e), {31'h0, rx_aligned}, {31'h0, (e < 3)});
         if (e < 3) begin
            for (int c = 0; c < 10; c++) step(32'h0, 4'h0, 4'h0, 4'h0);
            chk($sformatf("loss_gap%0d", e), {31'h0, rx_aligned}, 32'h1);
         end
      end
      step(32'h0, 4'h0, 4'h0, 4'h0);
      chk("loss_word_emitted", mgt_rx_data, 32'h0000CAFE);
      chk("loss_aligned_low", {31'h0, rx_aligned}, 32'h0);
`ifdef C2C_RX_ALIGNER_STATS_EN
      chk("loss_realign_cnt", {16'h0, realign_cnt}, 32'h1);
      chk("loss_err_word_cnt", {16'h0, err_word_cnt}, 32'h4);
`endif

      // Three errors, 64 clean words forgive one, next error leaves score at 3
      do_reset();
      for (int i = 0; i < 16; i++) step(32'h00BC0000, 4'b0100, 4'h0, 4'h0);
      chk("score_locked", {31'h0, rx_aligned}, 32'h1);
      for (int e = 0; e < 3; e++) begin
         step(32'h0, 4'h0, 4'h0, 4'h2);
         chk($sformatf("score_err%0d", e), {31'h0, rx_aligned}, 32'h1);
      end
      for (int c = 0; c < 64; c++) step(32'h0, 4'h0, 4'h0, 4'h0);
      step(32'h0, 4'h0, 4'h8, 4'h0);
      chk("score_after_forgive", {31'h0, rx_aligned}, 32'h1);
      step(32'h0, 4'h0, 4'h8, 4'h0);
      chk("score_reaches_limit", {31'h0, rx_aligned}, 32'h0);

      // VERIFY: lane-1 comma after lane-2 commas restarts the hunt on lane 1
      do_reset();
      step(32'h00BC0000, 4'b0100, 4'h0, 4'h0);
      step(32'h00BC0000, 4'b0100, 4'h0, 4'h0);
      step(32'h0000BC00, 4'b0010, 4'h0, 4'h0);
      chk("relane_aligned", {31'h0, rx_aligned}, 32'h0);
      step(32'h0, 4'h0, 4'h0, 4'h0);
      chk("relane_r1_data", mgt_rx_data, 32'h000000BC);
      chk("relane_r1_k", {28'h0, mgt_rx_k}, 32'h1);
      for (int i = 0; i < 16; i++) begin
         step(32'h0000BC00, 4'b0010, 4'h0, 4'h0);
         chk($sformatf("relane_lock%0d", i), {31'h0, rx_aligned}, {31'h0, (i == 15)});
      end
      chk("relane_out_data", mgt_rx_data, 32'h000000BC);
      chk("relane_out_k", {28'h0, mgt_rx_k}, 32'h1);

      // Asynchronous reset while aligned clears outputs without a clock edge
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst_data", mgt_rx_data, 32'h0);
      chk("async_rst_k", {28'h0, mgt_rx_k}, 32'h0);
      chk("async_rst_aligned", {31'h0, rx_aligned}, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/c2c_rx_aligner.md
C2C_RX_ALIGNER -- requirements
Module: c2c_rx_aligner

Interface
REQ-001 Parameter LOCK_COUNT, default 16: consecutive correctly placed commas needed to declare lock.
REQ-002 Parameter LOSS_ERR_COUNT, default 4: error-score threshold that drops lock.
REQ-003 Parameter GOOD_WORDS, default 64: consecutive clean words that decrement the error score by one.
REQ-004 c2c_phy_clk  in  1  sole clock; all logic is on its rising edge.
REQ-005 c2c_phy_rst_n  in  1  asynchronous, active-low reset.
REQ-006 gt_rx_data  in  32  raw decoded GT word; byte lanes are not aligned.
REQ-007 gt_rx_k  in  4  per-byte K flags for gt_rx_data.
REQ-008 gt_rx_disperr  in  4  per-byte disparity error.
REQ-009 gt_rx_notintable  in  4  per-byte not-in-table error.
REQ-010 mgt_rx_data  out  32  lane-aligned word; comma is in byte 0.
REQ-011 mgt_rx_k  out  4  K flags aligned with mgt_rx_data.
REQ-012 rx_aligned  out  1  high while the state is ALIGNED.

Function
REQ-013 A comma is a byte lane with K=1 and data 8'hBC; the word is "comma at lane L"; if several lanes match, the lowest lane SHALL be used.
REQ-014 A word is errored if any bit of gt_rx_disperr or gt_rx_notintable is set.
REQ-015 The block SHALL register the previous input word and form W = {cur, prev} (64 bits data, 8 bits K); output = W bytes r..r+3, where r (0..3) is the rotation.
REQ-016 Outputs SHALL be registered; byte at lane r of input word N appears on output byte 0 one clock after word N+1 is sampled.
REQ-017 The data path SHALL run in every state; only rx_aligned reflects lock.
REQ-018 States: HUNT, VERIFY, ALIGNED.
REQ-019 HUNT: on a non-errored comma at lane L, set r=L and lock_cnt=1, then go to VERIFY; otherwise stay in HUNT.
REQ-020 VERIFY: a comma at lane r increments lock_cnt.
REQ-021 VERIFY: a comma at any lane other than r, or an errored word, SHALL return to HUNT with lock_cnt=0.
REQ-022 VERIFY: when lock_cnt reaches LOCK_COUNT, go to ALIGNED with err_score=0 and good_cnt=0.
REQ-023 VERIFY: a word with no comma leaves lock_cnt unchanged.
REQ-024 ALIGNED: an errored word, or a comma at a lane other than r, increments err_score and clears good_cnt.
REQ-025 ALIGNED: a clean word increments good_cnt.
REQ-026 ALIGNED: when good_cnt reaches GOOD_WORDS, decrement err_score (floor 0) and clear good_cnt.
REQ-027 ALIGNED: when err_score reaches LOSS_ERR_COUNT, go to HUNT.
REQ-028 r SHALL NOT change in ALIGNED.
REQ-029 rx_aligned SHALL be registered: it rises the cycle after the VERIFY->ALIGNED transition and falls the cycle after the ALIGNED->HUNT transition.
REQ-030 The output word already carrying a lock-loss error SHALL still be emitted.
REQ-031 Counters SHALL saturate and never wrap; lock_cnt and err_score widths SHALL be sized from their parameters.

Reset
REQ-032 Reset asserted SHALL asynchronously force: mgt_rx_data=0, mgt_rx_k=0, rx_aligned=0, prev word=0, state=HUNT, r=0, and all counters=0.
REQ-033 Reset asserted mid-operation (any state) SHALL produce the same values.
REQ-034 The first comma is evaluated on the first clock after reset deassertion.

Configuration
REQ-035 With macro C2C_RX_ALIGNER_STATS_EN defined, the block SHALL add outputs realign_cnt[15:0] and err_word_cnt[15:0], both saturating and reset to 0.
REQ-036 realign_cnt counts ALIGNED->HUNT transitions.
REQ-037 err_word_cnt counts errored words in any state.
REQ-038 Without C2C_RX_ALIGNER_STATS_EN, these ports and their logic SHALL be absent, with no other change in behaviour.

Verification
REQ-039 Reset, then 16 words with a comma at lane 2 (data 32'h00BC0000, k 4'b0100) interleaved with data -> rx_aligned=1 on the cycle after the 16th comma; output comma word = 32'h000000BC, k=4'b0001.
REQ-040 In VERIFY, comma at lane 2 then a comma at lane 1 -> state HUNT, r=1; rx_aligned stays 0; lock needs 16 fresh lane-1 commas.
REQ-041 Aligned, 4 errored words separated by 10 clean words -> rx_aligned falls after the 4th error; with STATS_EN, realign_cnt=1 and err_word_cnt=4.
REQ-042 Aligned, 3 errors, then 64 clean words, then 1 error -> err_score=3, rx_aligned stays 1.
REQ-043 Word with commas at lanes 0 and 3 in HUNT -> r=0.
REQ-044 Reset pulsed while aligned -> all outputs 0 immediately, no clock needed.
